// File: rtl/truth_table_capture.sv
// Truth-table capture engine: steps a 3-input combinational DUT through all
// eight input vectors, samples its response and scores it against a golden table.
module truth_table_capture #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXPECTED = 8'h31
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] settle_cnt;
  logic       capture;
  logic       mismatch;
  logic [7:0] table_next;

  // idx is itself the registered stimulus, so a/b/c never glitch
  assign {a, b, c} = idx;

  always_comb begin
    capture         = (state == RUN) && (settle_cnt == SETTLE_LAST);
    mismatch        = (y != EXPECTED[idx]);
    table_next      = table_out;
    table_next[idx] = y;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= '0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_err  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            idx        <= '0;
            settle_cnt <= '0;
            table_out  <= '0;
            err_count  <= '0;
            first_err  <= '0;
            pass       <= 1'b0;
          end
        end
        RUN: begin
          if (capture) begin
            settle_cnt <= '0;
            table_out  <= table_next;
            if (mismatch) begin
              err_count <= err_count + 4'd1;
              if (err_count == 4'd0) begin
                first_err <= idx;
              end
            end
            // Last vector: park stimulus at 0 and score against the updated table
            if (idx == 3'd7) begin
              state <= DONE;
              done  <= 1'b1;
              idx   <= '0;
              pass  <= (table_next == EXPECTED);
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, meaning cycles each input vector is held before y is sampled (legal 1..15).
REQ-002 The block SHALL have parameter EXPECTED, default 8'h31, meaning the golden truth table, where bit k is expected y for {a,b,c}=k.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  request a capture run, sampled only in IDLE.
REQ-006 The block SHALL have ports a, b, c  output  1 each  registered stimulus to the combinational DUT; a is MSB of the vector index.
REQ-007 The block SHALL have port y  input  1  DUT response.
REQ-008 The block SHALL have port busy  output  1  high while a run is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse when a run completes.
REQ-010 The block SHALL have port table_out  output  8  captured truth table, bit k = y sampled for vector k.
REQ-011 The block SHALL have port pass  output  1  table_out == EXPECTED, valid from done until the next start.
REQ-012 The block SHALL have port err_count  output  4  number of mismatching bits, 0..8.
REQ-013 The block SHALL have port first_err  output  3  lowest mismatching index; 0 when err_count == 0.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start==1, RUN->DONE after vector 7 is captured, DONE->IDLE unconditionally after one cycle.
REQ-015 On the edge accepting start, the block SHALL clear idx, settle counter, table_out, err_count, first_err and pass, and drive {a,b,c}=3'd0.
REQ-016 In RUN, each vector SHALL be held exactly SETTLE cycles; on the SETTLE-th edge y SHALL be written to table_out[idx], and idx and {a,b,c} SHALL advance to idx+1 on that same edge.
REQ-017 On each capture edge, a mismatch (y != EXPECTED[idx]) SHALL increment err_count; the first mismatch of the run SHALL load first_err=idx.
REQ-018 Capture of idx 7 SHALL move the FSM to DONE, return {a,b,c} to 3'd0 and drive no further stimulus; idx SHALL NOT wrap into a second pass.
REQ-019 Latency SHALL be fixed: with start accepted at edge 0, captures SHALL occur at edges SETTLE*(k+1), k=0..7, and done SHALL be high in the cycle after edge 8*SETTLE.
REQ-020 busy SHALL be high in RUN and DONE and low in IDLE; done SHALL be high only in DONE.
REQ-021 pass SHALL be updated on the transition into DONE and held, together with table_out, err_count and first_err, until the next accepted start.
REQ-022 start SHALL be ignored in RUN and DONE, with no restart and no extension; start held high continuously SHALL begin a new run on the first IDLE cycle after DONE.
REQ-023 err_count SHALL saturate-free count to 8 (4-bit width suffices) and SHALL NOT wrap.

Reset
REQ-024 While reset_n is low, asynchronously and regardless of clk: state=IDLE, a=b=c=0, busy=0, done=0, table_out=0, pass=0, err_count=0, first_err=0, and internal counters=0.
REQ-025 Reset asserted mid-run SHALL abort the run with no done pulse; the first accepted start after release SHALL perform a complete 8-vector run.

Verification
REQ-026 Correct DUT y = ~b&~c | a&~b (truth table 0x31), SETTLE=2, one start pulse -> {a,b,c} steps 0..7 every 2 cycles; done after edge 16; table_out=0x31, pass=1, err_count=0, first_err=0.
REQ-027 y tied 0 -> table_out=0x00, err_count=3, first_err=0, pass=0.
REQ-028 y = a^b^c -> table_out=0x96, err_count=5 (mismatch mask 0xA7), first_err=0, pass=0.
REQ-029 Extra start pulses during RUN and DONE -> exactly one done pulse and unchanged timing; start held high -> back-to-back runs separated by exactly one IDLE cycle.
REQ-030 reset_n pulled low at cycle 7 of a run -> all outputs 0 immediately with no done; after release plus start, full run reproduces REQ-026 results.
REQ-031 SETTLE=1 -> {a,b,c} changes every cycle; done after edge 8; results identical to REQ-026.
